// File: rtl/strip_alloc_pkg.sv
// Shared constants, strip geometry tables and FSM state type for the strip allocator.
// Tables are fixed by the 128x128 equifilling layout; NUM_STRIPS must match them.
package strip_alloc_pkg;

    localparam int unsigned NUM_STRIPS = 13;
    localparam int unsigned ARRAY_SIZE = 128;
    localparam int unsigned DIM_W      = 6;
    localparam int unsigned COORD_W    = 8;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned ID_W       = 3;
    localparam int unsigned MAX_H      = 16;

    // Strip heights and base rows (running sum of the heights before each strip).
    localparam logic [4:0] STRIP_H [NUM_STRIPS] = '{
        5'd12, 5'd4, 5'd11, 5'd5, 5'd10, 5'd6, 5'd9,
        5'd7, 5'd8, 5'd8, 5'd16, 5'd16, 5'd16
    };

    localparam logic [COORD_W-1:0] Y_BASE [NUM_STRIPS] = '{
        8'd0, 8'd12, 8'd16, 8'd27, 8'd32, 8'd42, 8'd48,
        8'd57, 8'd64, 8'd72, 8'd80, 8'd96, 8'd112
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when a program of width w still fits after the current fill (9-bit sum).
    function automatic logic strip_room(input logic [COORD_W-1:0] fill,
                                        input logic [DIM_W-1:0]   w,
                                        input logic [8:0]         limit);
        return (9'(fill) + 9'(w)) <= limit;
    endfunction

endpackage

// File: rtl/strip_alloc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr_i, wrapping.
// The pointer register lives in the scheduler.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [2:0]         ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [2:0]         idx_o,
    output logic               any_o
);

    logic found;

    // Pass one covers [ptr, NUM_REQ), pass two wraps around to [0, ptr).
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found && valid_i[j] && (j >= int'(ptr_i))) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = 3'(j);
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = 3'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/strip_alloc_sched.sv
// Round-robin scheduler and strip-walking placer for the 128x128 equifilling strip array.
// Optional ALLOC_BEST_FIT_EN: full 13-strip scan, exact-height fit preferred over height+1.
module strip_alloc_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ARRAY_SIZE = strip_alloc_pkg::ARRAY_SIZE
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_REQ-1:0]                     req_valid_i,
    input  logic [6*NUM_REQ-1:0]                   req_height_i,
    input  logic [6*NUM_REQ-1:0]                   req_width_i,
    output logic [NUM_REQ-1:0]                     req_ready_o,
    input  logic                                   clear_i,
    output logic                                   rsp_valid_o,
    input  logic                                   rsp_ready_i,
    output logic [2:0]                             rsp_id_o,
    output logic                                   rsp_strike_o,
    output logic [7:0]                             rsp_x_o,
    output logic [7:0]                             rsp_y_o,
    output logic                                   busy_o,
    output logic [8*strip_alloc_pkg::NUM_STRIPS-1:0] fill_o
);

    import strip_alloc_pkg::*;

    state_t               state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      id_q;
    logic [DIM_W-1:0]     h_q;
    logic [DIM_W-1:0]     w_q;
    logic [IDX_W-1:0]     idx_q;
    logic [COORD_W-1:0]   fill_q [NUM_STRIPS];
    logic                 strike_q;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic [DIM_W-1:0]     gnt_h;
    logic [DIM_W-1:0]     gnt_w;

    logic                 bad_req;
    logic                 cur_room;
    logic                 cur_exact;
    logic                 cur_p1;
    logic                 last_strip;
    logic                 place_ok;
    logic [IDX_W-1:0]     place_idx;
    logic                 scan_done;
    logic                 grant_take;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Pick the winner's height and width off the packed request buses.
    always_comb begin
        gnt_h = '0;
        gnt_w = '0;
        for (int r = 0; r < int'(NUM_REQ); r++) begin
            if (gnt[r]) begin
                gnt_h = req_height_i[6*r +: 6];
                gnt_w = req_width_i[6*r +: 6];
            end
        end
    end

    assign grant_take  = (state_q == IDLE) && !clear_i && !rst_i && gnt_any;
    assign req_ready_o = grant_take ? gnt : '0;

    // Fit evaluation for the strip currently being visited.
    always_comb begin
        bad_req    = (h_q == '0) || (w_q == '0) || (h_q > 6'(MAX_H));
        cur_room   = strip_room(fill_q[idx_q], w_q, 9'(ARRAY_SIZE));
        cur_exact  = cur_room && (6'(STRIP_H[idx_q]) == h_q);
        cur_p1     = cur_room && (6'(STRIP_H[idx_q]) == (h_q + 6'd1));
        last_strip = (idx_q == 4'(NUM_STRIPS - 1));
    end

`ifdef ALLOC_BEST_FIT_EN
    logic             found_ex_q;
    logic             found_p1_q;
    logic [IDX_W-1:0] ex_idx_q;
    logic [IDX_W-1:0] p1_idx_q;

    // Remember the first exact and first height+1 candidates seen during the walk.
    always_ff @(posedge clk_i) begin
        if (rst_i || grant_take) begin
            found_ex_q <= 1'b0;
            found_p1_q <= 1'b0;
            ex_idx_q   <= '0;
            p1_idx_q   <= '0;
        end else if (state_q == SCAN) begin
            if (cur_exact && !found_ex_q) begin
                found_ex_q <= 1'b1;
                ex_idx_q   <= idx_q;
            end
            if (cur_p1 && !found_p1_q) begin
                found_p1_q <= 1'b1;
                p1_idx_q   <= idx_q;
            end
        end
    end

    // Decision on the last strip folds in that strip's own result.
    always_comb begin
        place_ok  = 1'b1;
        place_idx = idx_q;
        if (found_ex_q) begin
            place_idx = ex_idx_q;
        end else if (cur_exact) begin
            place_idx = idx_q;
        end else if (found_p1_q) begin
            place_idx = p1_idx_q;
        end else if (cur_p1) begin
            place_idx = idx_q;
        end else begin
            place_ok = 1'b0;
        end
        scan_done = last_strip;
    end
`else
    always_comb begin
        place_ok  = cur_exact || cur_p1;
        place_idx = idx_q;
        scan_done = place_ok || last_strip;
    end
`endif

    // Scheduler FSM, fill table and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            h_q      <= '0;
            w_q      <= '0;
            idx_q    <= '0;
            strike_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            for (int s = 0; s < int'(NUM_STRIPS); s++) begin
                fill_q[s] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        for (int s = 0; s < int'(NUM_STRIPS); s++) begin
                            fill_q[s] <= '0;
                        end
                    end else if (gnt_any) begin
                        h_q     <= gnt_h;
                        w_q     <= gnt_w;
                        id_q    <= gnt_idx;
                        idx_q   <= '0;
                        y_q     <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (bad_req) begin
                        strike_q <= 1'b1;
                        x_q      <= '0;
                        y_q      <= '0;
                        state_q  <= RESP;
                    end else if (scan_done) begin
                        if (place_ok) begin
                            strike_q          <= 1'b0;
                            x_q               <= fill_q[place_idx];
                            y_q               <= Y_BASE[place_idx];
                            fill_q[place_idx] <= fill_q[place_idx] + 8'(w_q);
                        end else begin
                            strike_q <= 1'b1;
                            x_q      <= '0;
                            y_q      <= '0;
                        end
                        state_q <= RESP;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        ptr_q   <= (id_q == 3'(NUM_REQ - 1)) ? 3'd0 : id_q + 3'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = id_q;
    assign rsp_strike_o = strike_q;
    assign rsp_x_o      = x_q;
    assign rsp_y_o      = y_q;

    for (genvar s = 0; s < int'(NUM_STRIPS); s++) begin : g_fill
        assign fill_o[8*s +: 8] = fill_q[s];
    end

endmodule

// File: tb/tb_strip_alloc_sched.sv
// Self-checking bench for strip_alloc_sched: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level placement model (honours ALLOC_BEST_FIT_EN).
module tb_strip_alloc_sched;

    localparam int NR = 4;
    localparam int NS = 13;
`ifdef ALLOC_BEST_FIT_EN
    localparam bit BF = 1'b1;
`else
    localparam bit BF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              rsp_ready;
    logic [NR-1:0]     valid;
    logic [6*NR-1:0]   hgt;
    logic [6*NR-1:0]   wid;
    logic [NR-1:0]     req_ready_o;
    logic              rsp_valid_o;
    logic [2:0]        rsp_id_o;
    logic              rsp_strike_o;
    logic [7:0]        rsp_x_o;
    logic [7:0]        rsp_y_o;
    logic              busy_o;
    logic [8*NS-1:0]   fill_o;

    always #5 clk = ~clk;

    strip_alloc_sched #(.NUM_REQ(NR), .ARRAY_SIZE(128)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (valid),
        .req_height_i (hgt),
        .req_width_i  (wid),
        .req_ready_o  (req_ready_o),
        .clear_i      (clear),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id_o),
        .rsp_strike_o (rsp_strike_o),
        .rsp_x_o      (rsp_x_o),
        .rsp_y_o      (rsp_y_o),
        .busy_o       (busy_o),
        .fill_o       (fill_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int SH [NS] = '{12, 4, 11, 5, 10, 6, 9, 7, 8, 8, 16, 16, 16};
    int m_fill [NS];
    int m_mode = 0;      // 0 idle, 1 working, 2 response pending
    int m_cnt, m_ptr = 0, m_id, m_strike, m_x, m_y, m_tgt, m_w;

    function automatic int y_base(input int s);
        int acc = 0;
        for (int i = 0; i < s; i++) acc += SH[i];
        return acc;
    endfunction

    function automatic bit room(input int s, input int w);
        return (m_fill[s] + w) <= 128;
    endfunction

    task automatic m_plan(input int h, input int w);
        m_w = w;
        m_tgt = -1;
        if (h == 0 || w == 0 || h > 16) begin
            m_cnt = 1;
        end else begin
            if (BF) begin
                for (int s = 0; s < NS; s++) if (m_tgt < 0 && SH[s] == h && room(s, w)) m_tgt = s;
                for (int s = 0; s < NS; s++) if (m_tgt < 0 && SH[s] == h + 1 && room(s, w)) m_tgt = s;
                m_cnt = NS;
            end else begin
                for (int s = 0; s < NS; s++)
                    if (m_tgt < 0 && (SH[s] == h || SH[s] == h + 1) && room(s, w)) m_tgt = s;
                m_cnt = (m_tgt < 0) ? NS : m_tgt + 1;
            end
        end
        m_strike = (m_tgt < 0);
        m_x = (m_tgt < 0) ? 0 : m_fill[m_tgt];
        m_y = (m_tgt < 0) ? 0 : y_base(m_tgt);
    endtask

    logic [NR-1:0]   e_rdy;
    logic [8*NS-1:0] e_fill;
    int              win;

    initial for (int s = 0; s < NS; s++) m_fill[s] = 0;

    // Compare outputs against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        e_rdy = '0;
        win = -1;
        if (!rst && m_mode == 0 && !clear) begin
            for (int i = 0; i < NR; i++) begin
                if (win < 0 && valid[(m_ptr + i) % NR]) win = (m_ptr + i) % NR;
            end
        end
        if (win >= 0) e_rdy[win] = 1'b1;
        for (int s = 0; s < NS; s++) e_fill[8*s +: 8] = 8'(m_fill[s]);
        if (chk_en) begin
            chk("req_ready", 128'(req_ready_o), 128'(e_rdy));
            chk("busy", 128'(busy_o), 128'(m_mode != 0));
            chk("rsp_valid", 128'(rsp_valid_o), 128'(m_mode == 2));
            chk("fill", 128'(fill_o), 128'(e_fill));
            if (m_mode == 2) begin
                chk("rsp_id", 128'(rsp_id_o), 128'(m_id));
                chk("rsp_strike", 128'(rsp_strike_o), 128'(m_strike));
                chk("rsp_x", 128'(rsp_x_o), 128'(m_x));
                chk("rsp_y", 128'(rsp_y_o), 128'(m_y));
            end
        end
        if (rst) begin
            m_mode = 0;
            m_ptr = 0;
            for (int s = 0; s < NS; s++) m_fill[s] = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (clear) begin
                        for (int s = 0; s < NS; s++) m_fill[s] = 0;
                    end else if (win >= 0) begin
                        m_id = win;
                        m_plan(int'(hgt[6*win +: 6]), int'(wid[6*win +: 6]));
                        m_mode = 1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        if (m_tgt >= 0) m_fill[m_tgt] += m_w;
                        m_mode = 2;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        m_ptr = (m_id + 1) % NR;
                        m_mode = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    int r_strike, r_x, r_y, g_cyc, r_cyc;
    int gorder [4];
    bit got;

    task automatic issue(input int r, input int h, input int w);
        bit ok = 1'b0;
        @(posedge clk); #1;
        valid[r] = 1'b1;
        hgt[6*r +: 6] = 6'(h);
        wid[6*r +: 6] = 6'(w);
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (req_ready_o[r]) begin
                ok = 1'b1;
                g_cyc = cyc;
            end
        end
        chk("grant_wait", 128'(ok), 128'(1));
        @(posedge clk); #1;
        valid[r] = 1'b0;
    endtask

    task automatic wait_rsp();
        bit ok = 1'b0;
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (rsp_valid_o && !seen) begin
                seen = 1'b1;
                r_cyc = cyc;
            end
            if (rsp_valid_o && rsp_ready) begin
                ok = 1'b1;
                r_strike = int'(rsp_strike_o);
                r_x = int'(rsp_x_o);
                r_y = int'(rsp_y_o);
            end
        end
        chk("rsp_wait", 128'(ok), 128'(1));
    endtask

    task automatic txn(input int r, input int h, input int w);
        issue(r, h, w);
        wait_rsp();
    endtask

    task automatic gather(input int want);
        int n = 0;
        logic [NR-1:0] gv;
        for (int t = 0; t < 300 && n < want; t++) begin
            @(negedge clk);
            if (|req_ready_o) begin
                gv = req_ready_o;
                for (int r = 0; r < NR; r++) if (gv[r]) gorder[n] = r;
                n++;
                @(posedge clk); #1;
                valid = valid & ~gv;
            end
        end
        chk("gather_count", 128'(n), 128'(want));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = !busy_o;
        end
        chk("idle_wait", 128'(ok), 128'(1));
    endtask

    function automatic int pick_h();
        int v = $urandom_range(0, 19);
        if (v == 0) return 0;
        if (v == 1) return $urandom_range(17, 63);
        return $urandom_range(1, 16);
    endfunction

    // ---------------- directed then random sequence ----------------
    initial begin
        logic [NR-1:0] g;
        rst = 1'b1; clear = 1'b0; rsp_ready = 1'b1;
        valid = '0; hgt = '0; wid = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset_fill", 128'(fill_o), 128'(0));
        chk("reset_busy", 128'(busy_o), 128'(0));
        chk("reset_rsp_valid", 128'(rsp_valid_o), 128'(0));
        chk("reset_rsp_fields", 128'({rsp_id_o, rsp_strike_o, rsp_x_o, rsp_y_o}), 128'(0));

        txn(0, 12, 20);
        chk("t1_xy", 128'({r_strike, r_x, r_y}), 128'({32'd0, 32'd0, 32'd0}));
        chk("t1_fill0", 128'(fill_o[7:0]), 128'(20));

        txn(0, 11, 30);
        chk("t2_x", 128'(r_x), 128'(BF ? 0 : 20));
        chk("t2_y", 128'(r_y), 128'(BF ? 16 : 0));
        chk("t2_fill", 128'(BF ? fill_o[23:16] : fill_o[7:0]), 128'(BF ? 30 : 50));

        txn(0, 4, 10);
        chk("t3_xy", 128'({r_x, r_y}), 128'({32'd0, 32'd12}));
        chk("t3_latency", 128'(r_cyc - g_cyc), 128'(BF ? 14 : 3));

        for (int i = 0; i < 7; i++) begin
            txn(0, 16, 63);
            chk("t4_strike", 128'(r_strike), 128'(i == 6));
            chk("t4_x", 128'(r_x), 128'(i < 6 ? (i % 2) * 63 : 0));
            chk("t4_y", 128'(r_y), 128'(i < 6 ? 80 + 16 * (i / 2) : 0));
        end
        chk("t4_fill_hi", 128'(fill_o[8*13-1:8*10]), 128'({8'd126, 8'd126, 8'd126}));

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int r = 0; r < NR; r++) begin
            hgt[6*r +: 6] = 6'd12;
            wid[6*r +: 6] = 6'(r + 1);
        end
        valid = '1;
        gather(4);
        for (int i = 0; i < 4; i++) chk("rr_order", 128'(gorder[i]), 128'(i));
        valid[1] = 1'b1;
        valid[3] = 1'b1;
        gather(2);
        chk("rr_again0", 128'(gorder[0]), 128'(1));
        chk("rr_again1", 128'(gorder[1]), 128'(3));
        wait_idle();

        txn(0, 0, 5);
        chk("h0_strike", 128'(r_strike), 128'(1));
        txn(0, 17, 5);
        chk("h17_strike", 128'(r_strike), 128'(1));
        chk("strike_fill", 128'(fill_o), 128'(16));

        @(posedge clk); #1;
        clear = 1'b1;
        valid[0] = 1'b1;
        hgt[5:0] = 6'd12;
        wid[5:0] = 6'd5;
        @(negedge clk);
        chk("clear_no_grant", 128'(req_ready_o), 128'(0));
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("clear_fill", 128'(fill_o), 128'(0));
        chk("clear_then_grant", 128'(req_ready_o), 128'(1));
        g_cyc = cyc;
        @(posedge clk); #1 valid[0] = 1'b0;
        wait_rsp();
        chk("clear_rsp", 128'({r_strike, r_x, r_y}), 128'(0));

        @(posedge clk); #1 rsp_ready = 1'b0;
        issue(0, 5, 7);
        valid[1] = 1'b1;
        hgt[11:6] = 6'd12;
        wid[11:6] = 6'd1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = rsp_valid_o;
        end
        chk("hold_rsp_wait", 128'(got), 128'(1));
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_valid", 128'(rsp_valid_o), 128'(1));
            chk("hold_xy", 128'({rsp_strike_o, rsp_x_o, rsp_y_o}), 128'({1'b0, 8'd0, 8'd27}));
            chk("hold_no_grant", 128'(req_ready_o), 128'(0));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        gather(1);
        chk("hold_next", 128'(gorder[0]), 128'(1));
        wait_rsp();
        chk("hold_next_x", 128'(r_x), 128'(5));

        txn(0, 8, 4);
        chk("h8_y", 128'(r_y), 128'(BF ? 64 : 48));
        chk("h8_latency", 128'(r_cyc - g_cyc), 128'(BF ? 14 : 8));

        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            g = req_ready_o;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 399) == 0);
            clear = ($urandom_range(0, 19) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NR; r++) begin
                if (g[r]) begin
                    valid[r] = 1'b0;
                end else if (!valid[r] && $urandom_range(0, 2) == 0) begin
                    valid[r] = 1'b1;
                    hgt[6*r +: 6] = 6'(pick_h());
                    wid[6*r +: 6] = 6'($urandom_range(0, 40));
                end
            end
        end

        @(posedge clk); #1;
        rst = 1'b0; clear = 1'b0; valid = '0; rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
